interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  8051 interrupt controller, directly upstream of program_counter. Latches the five
//  standard sources and applies IE/IP enable and priority. Presents one request
//  (int, int_vec) to the PC and tracks in-service levels through int_ack and reti.
//  Generates hardware flag-clear pulses for the timer and edge-mode external sources.
// PARAMETERS
//  VEC_BASE    8'h03  vector of source 0 (IE0)
//  VEC_STRIDE  8'h08  vector spacing; vec(i) = VEC_BASE + i*VEC_STRIDE (8-bit, no wrap for i<=4)
// PORTS
//  clock        in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low; clears all state
//  ext_int0_n   in   1  external interrupt 0 pin, active-low
//  ext_int1_n   in   1  external interrupt 1 pin, active-low
//  it0, it1     in   1  TCON.IT0/IT1: 1=falling-edge, 0=level mode
//  tf0, tf1     in   1  timer overflow flags (level)
//  ser_req      in   1  RI|TI from serial unit (level)
//  ie_reg       in   8  IE SFR: [7]=EA, [4]=ES, [3]=ET1, [2]=EX1, [1]=ET0, [0]=EX0
//  ip_reg       in   8  IP SFR, same bit map [4:0]; 1=high priority
//  int_ack      in   1  PC accepted the vector (1 cycle)
//  reti         in   1  RETI executed (1 cycle)
//  int          out  1  interrupt request to PC
//  int_vec      out  8  vector; stable whenever int=1
//  ie0_flag, ie1_flag out 1  TCON.IE0/IE1 readback
//  tf0_clr, tf1_clr, ie0_clr, ie1_clr out 1  1-cycle hardware clear pulses
//  in_service   out  2  [1]=high level active, [0]=low level active
// BEHAVIOUR
//  - Reset (reset=0, any time, incl. mid-handshake): int=0, int_vec=8'h00, all *_clr=0,
//    ie0/ie1_flag=0, in_service=2'b00; the request in flight is dropped, not resumed.
//  - Edge mode: a 1->0 on the (synchronised) pin sets ieX_flag; it is cleared by ieX_clr.
//    Level mode: ieX_flag = ~pin, registered every cycle; ieX_clr is not generated.
//  - Source i is eligible when its flag is set, EA=1, and ie_reg[i]=1.
//  - Admission: high-priority eligible source when in_service[1]=0; low-priority source
//    only when in_service==2'b00. High preempts low; nothing preempts high.
//  - Within a level, fixed poll order IE0 > TF0 > IE1 > TF1 > SER; high level wins first.
//  - FSM IDLE -> REQ -> IDLE. IDLE: if any source is admissible at posedge, register
//    int=1, int_vec=vec(winner), the winner index, and its level; go to REQ.
//    Latency = 1 cycle from flag visible to int=1.
//  - REQ: int and int_vec are held; no re-arbitration; enable/flag changes are ignored
//    until ack. On a posedge with int_ack=1: int=0 next cycle, in_service[level] set,
//    and for TF0/TF1/IE0(edge)/IE1(edge) the matching *_clr pulses for exactly 1 cycle.
//    SER is never cleared by hardware. Return to IDLE; int stays low for >=1 cycle.
//  - int_ack while IDLE is ignored.
//  - reti clears the highest set in_service bit; reti with in_service=0 is a no-op.
//  - reti and int_ack in the same cycle: reti clears the bit that was highest before
//    the edge, and ack sets its level bit; the net result is the OR of both updates.
//  - Flags set in the same cycle as their clear pulse: the set wins (the event is not lost).
// CONFIGURATION
//  EXT_INT_SYNC_EN defined: ext_int*_n pass through a 2-flop synchroniser (reset to 1)
//    before edge/level detection; this adds 2 cycles of pin-to-flag latency.
//  Not defined: a single sampling register (reset to 1) feeds edge detection only;
//    the pin-to-flag latency is 1 cycle.
// STRUCTURE
//  Package int_ctrl_pkg: source index constants (SRC_IE0..SRC_SER), NUM_SRC=5,
//    FSM state encoding (ST_IDLE, ST_REQ), IE/IP bit position constants.
//  Sub-module ext_int_detect (one per external pin): optional synchroniser,
//    edge/level mode, flag register, clear input. Instantiated twice.
//  Top level: priority arbiter, request FSM, in-service register, clear-pulse logic.
// TESTING
//  1 reset=0 with tf0=1 and ie_reg=8'h82 -> int=0, int_vec=00, in_service=00; reset=1 -> int=1, vec=0B after 1 clk
//  2 ie_reg=8'h82, tf0=1; ack -> int=0 next clk, tf0_clr 1-cycle pulse, in_service=01; reti -> 00
//  3 ie_reg=8'h83, it0=1, ext_int0_n falls in the same clk tf0=1 -> vec 03 first; ack+reti -> vec 0B
//  4 TF0 low in service, ip_reg=8'h08, tf1=1, ie_reg=8'h8A -> int, vec=1B, in_service=11 after ack;
//    set IP.EX0 with ie0 pending -> no int until reti
//  5 ie_reg=8'h1F (EA=0), all sources active -> int never asserts; set EA -> vec 03
//  6 int=1 held 5 clks without ack while tf0 drops -> vec stays 0B; reset mid-REQ -> int=0, no clr pulse

Source files
------------

// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : int_ctrl_pkg
// Purpose : Shared constants, FSM encoding and helpers for the 8051 interrupt
//           controller (source indices, IE/IP bit map, poll-order picker).
// Revision: 1.0  initial release
// ============================================================================
package int_ctrl_pkg;

  localparam int NUM_SRC = 5;

  // Source index doubles as the IE/IP bit position and the poll order.
  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SER = 3'd4;

  localparam int IE_EX0_BIT = 0;
  localparam int IE_ET0_BIT = 1;
  localparam int IE_EX1_BIT = 2;
  localparam int IE_ET1_BIT = 3;
  localparam int IE_ES_BIT  = 4;
  localparam int IE_EA_BIT  = 7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } req_state_e;

  // Lowest set index wins, which is the fixed 8051 poll order.
  function automatic logic [2:0] first_set(input logic [NUM_SRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage : int_ctrl_pkg
`default_nettype wire

// File: rtl/ext_int_detect.sv
`default_nettype none
// ============================================================================
// Module  : ext_int_detect
// Purpose : External interrupt pin conditioning: edge/level detection and the
//           TCON.IEx flag. Optional 2-flop synchroniser via EXT_INT_SYNC_EN.
// Revision: 1.0  initial release
// ============================================================================
module ext_int_detect
  import int_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic pin_n,
  input  logic edge_mode,
  input  logic flag_clr,
  output logic flag
);

  logic pin_s;
  logic samp_q, samp_d;
  logic flag_q, flag_d;
  logic fall;

`ifdef EXT_INT_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin_n;
      sync2_q <= sync1_q;
    end
  end

  assign pin_s = sync2_q;
`else
  assign pin_s = pin_n;
`endif

  always_comb begin
    samp_d = pin_s;
    fall   = samp_q & ~pin_s;
    // A fresh falling edge beats a simultaneous clear so the event is kept.
    if (edge_mode) flag_d = (flag_q & ~flag_clr) | fall;
    else           flag_d = ~pin_s;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      samp_q <= 1'b1;
      flag_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule : ext_int_detect
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module  : interrupt_controller
// Purpose : 8051 interrupt controller: IE/IP arbitration, request handshake to
//           the PC, in-service tracking and hardware flag clears.
//           Optional macro: EXT_INT_SYNC_EN (pin synchronisers).
//           The request output is int_req since 'int' is a reserved word.
// Revision: 1.0  initial release
// ============================================================================
module interrupt_controller
  import int_ctrl_pkg::*;
#(
  parameter logic [7:0] VEC_BASE   = 8'h03,
  parameter logic [7:0] VEC_STRIDE = 8'h08
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ext_int0_n,
  input  logic       ext_int1_n,
  input  logic       it0,
  input  logic       it1,
  input  logic       tf0,
  input  logic       tf1,
  input  logic       ser_req,
  input  logic [7:0] ie_reg,
  input  logic [7:0] ip_reg,
  input  logic       int_ack,
  input  logic       reti,
  output logic       int_req,
  output logic [7:0] int_vec,
  output logic       ie0_flag,
  output logic       ie1_flag,
  output logic       tf0_clr,
  output logic       tf1_clr,
  output logic       ie0_clr,
  output logic       ie1_clr,
  output logic [1:0] in_service
);

  req_state_e state_q, state_d;
  logic       int_q, int_d;
  logic [7:0] vec_q, vec_d;
  logic [2:0] win_q, win_d;
  logic       lvl_q, lvl_d;
  logic [1:0] in_service_q, in_service_d;
  logic       tf0_clr_q, tf0_clr_d;
  logic       tf1_clr_q, tf1_clr_d;
  logic       ie0_clr_q, ie0_clr_d;
  logic       ie1_clr_q, ie1_clr_d;

  logic [NUM_SRC-1:0] src_flag;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] admit_hi;
  logic [NUM_SRC-1:0] admit_lo;
  logic               unused_ok;

  assign unused_ok = ^{ie_reg[6:5], ip_reg[7:5]};

  ext_int_detect u_ext0 (
    .clock    (clock),
    .reset    (reset),
    .pin_n    (ext_int0_n),
    .edge_mode(it0),
    .flag_clr (ie0_clr_q),
    .flag     (ie0_flag)
  );

  ext_int_detect u_ext1 (
    .clock    (clock),
    .reset    (reset),
    .pin_n    (ext_int1_n),
    .edge_mode(it1),
    .flag_clr (ie1_clr_q),
    .flag     (ie1_flag)
  );

  function automatic logic [7:0] vec_of(input logic [2:0] idx);
    return VEC_BASE + VEC_STRIDE * {5'b0, idx};
  endfunction

  always_comb begin
    src_flag          = '0;
    src_flag[SRC_IE0] = ie0_flag;
    src_flag[SRC_TF0] = tf0;
    src_flag[SRC_IE1] = ie1_flag;
    src_flag[SRC_TF1] = tf1;
    src_flag[SRC_SER] = ser_req;
    elig     = src_flag & ie_reg[NUM_SRC-1:0] & {NUM_SRC{ie_reg[IE_EA_BIT]}};
    // High may preempt low; low only runs with nothing in service.
    admit_hi = in_service_q[1] ? '0 : (elig & ip_reg[NUM_SRC-1:0]);
    admit_lo = (in_service_q == 2'b00) ? (elig & ~ip_reg[NUM_SRC-1:0]) : '0;
  end

  always_comb begin
    state_d      = state_q;
    int_d        = int_q;
    vec_d        = vec_q;
    win_d        = win_q;
    lvl_d        = lvl_q;
    in_service_d = in_service_q;
    tf0_clr_d    = 1'b0;
    tf1_clr_d    = 1'b0;
    ie0_clr_d    = 1'b0;
    ie1_clr_d    = 1'b0;

    // reti acts on the pre-edge value; an ack below ORs its own level in.
    if (reti) begin
      if (in_service_q[1]) in_service_d[1] = 1'b0;
      else                 in_service_d[0] = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (|admit_hi) begin
          win_d   = first_set(admit_hi);
          lvl_d   = 1'b1;
          int_d   = 1'b1;
          vec_d   = vec_of(win_d);
          state_d = ST_REQ;
        end else if (|admit_lo) begin
          win_d   = first_set(admit_lo);
          lvl_d   = 1'b0;
          int_d   = 1'b1;
          vec_d   = vec_of(win_d);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          int_d               = 1'b0;
          in_service_d[lvl_q] = 1'b1;
          state_d             = ST_IDLE;
          case (win_q)
            SRC_IE0: ie0_clr_d = it0;
            SRC_TF0: tf0_clr_d = 1'b1;
            SRC_IE1: ie1_clr_d = it1;
            SRC_TF1: tf1_clr_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      int_q        <= 1'b0;
      vec_q        <= 8'h00;
      win_q        <= 3'd0;
      lvl_q        <= 1'b0;
      in_service_q <= 2'b00;
      tf0_clr_q    <= 1'b0;
      tf1_clr_q    <= 1'b0;
      ie0_clr_q    <= 1'b0;
      ie1_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_q        <= int_d;
      vec_q        <= vec_d;
      win_q        <= win_d;
      lvl_q        <= lvl_d;
      in_service_q <= in_service_d;
      tf0_clr_q    <= tf0_clr_d;
      tf1_clr_q    <= tf1_clr_d;
      ie0_clr_q    <= ie0_clr_d;
      ie1_clr_q    <= ie1_clr_d;
    end
  end

  assign int_req    = int_q;
  assign int_vec    = vec_q;
  assign in_service = in_service_q;
  assign tf0_clr    = tf0_clr_q;
  assign tf1_clr    = tf1_clr_q;
  assign ie0_clr    = ie0_clr_q;
  assign ie1_clr    = ie1_clr_q;

endmodule : interrupt_controller
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_interrupt_controller
// Purpose : Directed self-checking bench for interrupt_controller.
// Revision: 1.0  initial release
// ============================================================================
module tb_interrupt_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       ext_int0_n, ext_int1_n, it0, it1, tf0, tf1, ser_req;
  logic [7:0] ie_reg, ip_reg;
  logic       int_ack, reti;
  logic       int_req;
  logic [7:0] int_vec;
  logic       ie0_flag, ie1_flag, tf0_clr, tf1_clr, ie0_clr, ie1_clr;
  logic [1:0] in_service;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  interrupt_controller dut (
    .clock     (clock),
    .reset     (reset),
    .ext_int0_n(ext_int0_n),
    .ext_int1_n(ext_int1_n),
    .it0       (it0),
    .it1       (it1),
    .tf0       (tf0),
    .tf1       (tf1),
    .ser_req   (ser_req),
    .ie_reg    (ie_reg),
    .ip_reg    (ip_reg),
    .int_ack   (int_ack),
    .reti      (reti),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .ie0_flag  (ie0_flag),
    .ie1_flag  (ie1_flag),
    .tf0_clr   (tf0_clr),
    .tf1_clr   (tf1_clr),
    .ie0_clr   (ie0_clr),
    .ie1_clr   (ie1_clr),
    .in_service(in_service)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] clrs();
    return {4'h0, tf0_clr, tf1_clr, ie0_clr, ie1_clr};
  endfunction

  initial begin
    reset = 1'b0;
    ext_int0_n = 1'b1; ext_int1_n = 1'b1; it0 = 1'b0; it1 = 1'b0;
    tf0 = 1'b1; tf1 = 1'b0; ser_req = 1'b0;
    ie_reg = 8'h82; ip_reg = 8'h00; int_ack = 1'b0; reti = 1'b0;

    // 1: reset state, then first request one clock after release
    tick(); tick();
    chk("rst_int", {7'b0, int_req}, 8'h00);
    chk("rst_vec", int_vec, 8'h00);
    chk("rst_insvc", {6'b0, in_service}, 8'h00);
    chk("rst_clr", clrs(), 8'h00);
    chk("rst_flags", {6'b0, ie1_flag, ie0_flag}, 8'h00);
    reset = 1'b1;
    tick();
    chk("t1_int", {7'b0, int_req}, 8'h01);
    chk("t1_vec", int_vec, 8'h0B);

    // 2: ack -> tf0_clr pulse and low level in service; reti releases it
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t2_int_low", {7'b0, int_req}, 8'h00);
    chk("t2_tf0clr", clrs(), 8'h08);
    chk("t2_insvc", {6'b0, in_service}, 8'h01);
    tf0 = 1'b0;
    tick();
    chk("t2_clr_end", clrs(), 8'h00);
    reti = 1'b1; tick(); reti = 1'b0;
    chk("t2_reti", {6'b0, in_service}, 8'h00);

    // 3: IE0 edge flag and TF0 both pending -> IE0 first, then TF0
    ie_reg = 8'h83; it0 = 1'b1; ext_int0_n = 1'b0;
    tick();
    chk("t3_ie0flag", {7'b0, ie0_flag}, 8'h01);
    chk("t3_no_int", {7'b0, int_req}, 8'h00);
    tf0 = 1'b1;
    tick();
    chk("t3_vec03", int_vec, 8'h03);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t3_ie0clr", clrs(), 8'h02);
    chk("t3_insvc", {6'b0, in_service}, 8'h01);
    tick();
    chk("t3_flag_clr", {7'b0, ie0_flag}, 8'h00);
    chk("t3_blocked", {7'b0, int_req}, 8'h00);
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    chk("t3_vec0b", int_vec, 8'h0B);
    chk("t3_int", {7'b0, int_req}, 8'h01);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tf0 = 1'b0; ext_int0_n = 1'b1;
    reti = 1'b1; tick(); reti = 1'b0;
    chk("t3_done", {6'b0, in_service}, 8'h00);

    // 4: high TF1 preempts low TF0; high IE0 waits for reti of the high level
    ie_reg = 8'h8A; ip_reg = 8'h08; tf0 = 1'b1;
    tick();
    chk("t4_vec0b", int_vec, 8'h0B);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tf0 = 1'b0; tf1 = 1'b1;
    tick();
    chk("t4_vec1b", int_vec, 8'h1B);
    chk("t4_int", {7'b0, int_req}, 8'h01);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t4_insvc11", {6'b0, in_service}, 8'h03);
    chk("t4_tf1clr", clrs(), 8'h04);
    tf1 = 1'b0; ie_reg = 8'h8B; ip_reg = 8'h09; ext_int0_n = 1'b0;
    tick();
    tick();
    chk("t4_held_off", {7'b0, int_req}, 8'h00);
    reti = 1'b1; tick(); reti = 1'b0;
    chk("t4_reti_hi", {6'b0, in_service}, 8'h01);
    chk("t4_still_off", {7'b0, int_req}, 8'h00);
    tick();
    chk("t4_vec03", int_vec, 8'h03);
    chk("t4_int2", {7'b0, int_req}, 8'h01);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    ext_int0_n = 1'b1;
    reti = 1'b1; tick();
    chk("t4_reti1", {6'b0, in_service}, 8'h01);
    tick(); reti = 1'b0;
    chk("t4_reti2", {6'b0, in_service}, 8'h00);
    reti = 1'b1; tick(); reti = 1'b0;
    chk("t4_reti_noop", {6'b0, in_service}, 8'h00);

    // 5: EA=0 masks everything; ack in IDLE ignored; level mode; reti+ack
    ie_reg = 8'h1F; ip_reg = 8'h00; it0 = 1'b0; it1 = 1'b0;
    ext_int0_n = 1'b0; ext_int1_n = 1'b0; tf0 = 1'b1; tf1 = 1'b1; ser_req = 1'b1;
    tick(); tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t5_ea_off", {7'b0, int_req}, 8'h00);
    chk("t5_idle_ack", {6'b0, in_service}, 8'h00);
    chk("t5_lvlflag", {6'b0, ie1_flag, ie0_flag}, 8'h03);
    ie_reg = 8'h9F;
    tick();
    chk("t5_vec03", int_vec, 8'h03);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t5_no_lvlclr", clrs(), 8'h00);
    ip_reg = 8'h10;
    tick();
    chk("t5_vec23", int_vec, 8'h23);
    int_ack = 1'b1; reti = 1'b1; tick(); int_ack = 1'b0; reti = 1'b0;
    chk("t5_ack_reti", {6'b0, in_service}, 8'h02);
    chk("t5_ser_noclr", clrs(), 8'h00);
    ie_reg = 8'h00; ip_reg = 8'h00; tf0 = 1'b0; tf1 = 1'b0; ser_req = 1'b0;
    ext_int0_n = 1'b1; ext_int1_n = 1'b1;
    reti = 1'b1; tick(); reti = 1'b0;
    chk("t5_clean", {6'b0, in_service}, 8'h00);

    // 6: held request ignores source changes; reset mid-REQ drops it
    ie_reg = 8'h82; tf0 = 1'b1;
    tick();
    tf0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_vec", int_vec, 8'h0B);
      chk("t6_hold_int", {7'b0, int_req}, 8'h01);
    end
    reset = 1'b0; int_ack = 1'b1;
    #1;
    chk("t6_async_rst", {7'b0, int_req}, 8'h00);
    tick();
    chk("t6_rst_noclr", clrs(), 8'h00);
    chk("t6_rst_insvc", {6'b0, in_service}, 8'h00);
    reset = 1'b1; int_ack = 1'b0;
    tick(); tick();
    chk("t6_dropped", {7'b0, int_req}, 8'h00);
    chk("t6_dropped_clr", clrs(), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_interrupt_controller
`default_nettype wire
